// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divider sequencing front-end.
// Holds the op/state enums, the classifier result struct and the ALU op encodings.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_DIV  = 4'hC;
    localparam logic [3:0] ALU_REM  = 4'hE;

    typedef struct packed {
        logic        is_special;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg;
        logic [31:0] abs_a;
        logic [31:0] abs_b;
    } div_class_t;

    // INT_MIN maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs_mag(input logic is_neg, input logic [31:0] v);
        return is_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational classifier: resolves RISC-V divide corner cases and produces the
// unsigned magnitudes plus sign flag for everything the divider must handle.
module div_special_case
    import div_pkg::*;
(
    input  div_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output div_class_t  cls
);

    logic is_signed;
    logic sa;
    logic sb;

    // NOTE: every field gets a default before the priority chain, so no path leaves a latch.
    always_comb begin
        is_signed = (op == DIV) || (op == REM);
        sa        = is_signed & a[31];
        sb        = is_signed & b[31];

        cls            = '0;
        cls.abs_a      = abs_mag(sa, a);
        cls.abs_b      = abs_mag(sb, b);
        cls.neg        = (op == DIV) ? (sa ^ sb) : ((op == REM) ? sa : 1'b0);

        if (b == '0) begin
            cls.is_special = 1'b1;
            cls.q          = ALL_ONES;
            cls.r          = a;
        end else if (is_signed && a == INT_MIN && b == ALL_ONES) begin
            cls.is_special = 1'b1;
            cls.q          = INT_MIN;
        end else if (cls.abs_a == '0) begin
            cls.is_special = 1'b1;
        end else if (cls.abs_a == cls.abs_b) begin
            cls.is_special = 1'b1;
            cls.q          = (op == DIV && (sa ^ sb)) ? ALL_ONES : 32'd1;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer between execute and the iterative divider: answers corner cases locally,
// issues general cases as unsigned magnitudes and returns a one-cycle response pulse.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [3:0]  div_op_o,
    output logic        div_neg_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic [31:0] div_quot_i,
    input  logic [31:0] div_rem_i,
    input  logic        div_stall_i
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    div_state_e    state_q, state_d;
    div_op_e       op_in;
    div_class_t    cls;
    logic          req_is_rem;
    logic [3:0]    alu_op_q;
    logic [31:0]   a_q, b_q, res_q, held_q;
    logic          neg_q;
    logic [WD_W-1:0] wd_q;
    logic          launch, capture_special, capture_general, timeout;

    assign op_in      = div_op_e'(req_op_i);
    assign req_is_rem = (op_in == REM) || (op_in == REMU);

    div_special_case u_special (
        .op  (op_in),
        .a   (req_a_i),
        .b   (req_b_i),
        .cls (cls)
    );

    always_comb begin
        state_d         = state_q;
        launch          = 1'b0;
        capture_special = 1'b0;
        capture_general = 1'b0;
        timeout         = 1'b0;
        unique case (state_q)
            IDLE: if (req_valid_i && !flush_i) begin
                if (cls.is_special) begin
                    capture_special = 1'b1;
                    state_d         = DONE;
                end else begin
                    launch  = 1'b1;
                    state_d = RUN;
                end
            end
            // A flush on the divider's completion cycle needs no drain: it is already idle.
            RUN: if (flush_i) begin
                state_d = div_stall_i ? DRAIN : IDLE;
            end else if (!div_stall_i) begin
                capture_general = 1'b1;
                state_d         = DONE;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                state_d = IDLE;
            end
            DRAIN: if (!div_stall_i) state_d = IDLE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            alu_op_q <= ALU_NONE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            held_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                alu_op_q <= req_is_rem ? ALU_REM : ALU_DIV;
                a_q      <= cls.abs_a;
                b_q      <= cls.abs_b;
                neg_q    <= cls.neg;
                wd_q     <= '0;
            end else if (state_q == RUN) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (capture_special) res_q <= req_is_rem ? cls.r : cls.q;
            else if (capture_general) res_q <= (alu_op_q == ALU_REM) ? div_rem_i : div_quot_i;
            if (rsp_valid_o) held_q <= res_q;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == DONE) && !flush_i;
    assign rsp_data_o  = rsp_valid_o ? res_q : held_q;
    assign err_o       = timeout;
    assign div_op_o    = (state_q == RUN || state_q == DRAIN) ? alu_op_q : ALU_NONE;
    assign div_neg_o   = neg_q;
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl with a behavioural RV32M result model,
// a simple stalling divider stand-in and a per-cycle response checker.
module tb_div_seq_ctrl;
    import div_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_op_i = 2'd0;
    logic [31:0] req_a_i = '0;
    logic [31:0] req_b_i = '0;
    logic        flush_i = 1'b0;
    logic        req_ready_o, rsp_valid_o, busy_o, err_o, div_neg_o, div_stall_i;
    logic [31:0] rsp_data_o, div_a_o, div_b_o, div_quot_i, div_rem_i;
    logic [3:0]  div_op_o;

    div_seq_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .flush_i(flush_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o), .err_o(err_o),
        .div_op_o(div_op_o), .div_neg_o(div_neg_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_quot_i(div_quot_i), .div_rem_i(div_rem_i), .div_stall_i(div_stall_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider stand-in: stalls for stall_len cycles of a held request, then answers.
    int stall_len = 3;
    int dcnt = 0;
    always @(posedge clk_i)
        if (reset_i || div_op_o == ALU_NONE) dcnt <= 0;
        else dcnt <= dcnt + 1;
    assign div_stall_i = (div_op_o != ALU_NONE) && (dcnt < stall_len);
    always_comb begin
        div_quot_i = '0;
        div_rem_i  = '0;
        if (div_b_o != '0) begin
            div_quot_i = div_a_o / div_b_o;
            div_rem_i  = div_a_o % div_b_o;
        end
        if (div_neg_o) begin
            div_quot_i = -div_quot_i;
            div_rem_i  = -div_rem_i;
        end
    end

    // Architectural RV32M results.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
        return ((op == 2'd0 || op == 2'd2) && x[31]) ? -x : x;
    endfunction

    function automatic logic ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            || (mag(op, a) == 0) || (mag(op, a) == mag(op, b));
    endfunction

    function automatic logic ref_neg(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == 2'd0) ? (a[31] ^ b[31]) : ((op == 2'd2) ? a[31] : 1'b0);
    endfunction

    // Expectations owned by the stimulus process; last_data owned by the checker.
    logic        pend_valid = 1'b0;
    int          pend_cycle = 0;
    logic [31:0] pend_data = '0;
    logic        err_pend = 1'b0;
    int          err_cycle = 0;
    logic [31:0] last_data = '0;
    int          div_active = 0;

    always @(negedge clk_i) begin : compare
        logic exp_v;
        if (div_op_o != ALU_NONE) div_active++;
        if (reset_i) begin
            last_data = '0;
        end else begin
            exp_v = pend_valid && (cyc == pend_cycle);
            check("rsp_valid", rsp_valid_o, exp_v);
            if (exp_v) begin
                check("rsp_data", rsp_data_o, pend_data);
                last_data = pend_data;
            end else begin
                check("rsp_hold", rsp_data_o, last_data);
            end
            check("err", err_o, err_pend && (cyc == err_cycle));
            check("ready_vs_busy", req_ready_o, !busy_o);
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lat);
        logic [31:0] mdl;
        logic        sp;
        int          acc, act0;
        mdl = ref_result(op, a, b);
        sp  = ref_special(op, a, b);
        check({name, "_model"}, mdl, lit);
        check({name, "_ready"}, req_ready_o, 1'b1);
        stall_len   = lat;
        act0        = div_active;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        acc         = cyc;
        pend_data   = mdl;
        pend_cycle  = sp ? acc : acc + lat + 1;
        pend_valid  = 1'b1;
        if (!sp) begin
            @(negedge clk_i);
            check({name, "_div_op"}, div_op_o, (op[1] ? ALU_REM : ALU_DIV));
            check({name, "_div_a"}, div_a_o, mag(op, a));
            check({name, "_div_b"}, div_b_o, mag(op, b));
            check({name, "_div_neg"}, div_neg_o, ref_neg(op, a, b));
        end
        wait_cyc(pend_cycle + 1);
        pend_valid = 1'b0;
        if (sp) check({name, "_no_div_req"}, div_active, act0);
    endtask

    initial begin : stim
        int acc, act0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", req_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_div_op", div_op_o, ALU_NONE);
        check("rst_div_a", div_a_o, 32'd0);
        check("rst_data", rsp_data_o, 32'd0);

        issue("div_100_7",      2'd0, 32'd100,        32'd7,          32'd14,         3);
        issue("div_m100_7",     2'd0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  5);
        issue("rem_m100_7",     2'd2, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  0);
        issue("divu_by0",       2'd1, 32'h0000_DEAD,  32'd0,          32'hFFFF_FFFF,  3);
        issue("rem_by0",        2'd2, 32'h0000_1234,  32'd0,          32'h0000_1234,  3);
        issue("div_ovf",        2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3);
        issue("rem_ovf",        2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          3);
        issue("div_m5_5",       2'd0, 32'hFFFF_FFFB,  32'd5,          32'hFFFF_FFFF,  3);
        issue("remu_0_9",       2'd3, 32'd0,          32'd9,          32'd0,          3);
        issue("div_m7_m7",      2'd0, 32'hFFFF_FFF9,  32'hFFFF_FFF9,  32'd1,          3);
        issue("rem_7_m3",       2'd2, 32'd7,          32'hFFFF_FFFD,  32'd1,          2);
        issue("divu_big",       2'd1, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  4);

        // Flush in RUN: drain until the divider stalls no more, then idle without a response.
        stall_len   = 6;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_a_i = 32'd1000; req_b_i = 32'd3;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        acc = cyc;
        wait_cyc(acc + 2);
        flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        wait_cyc(acc + 6);
        check("drain_ready", req_ready_o, 1'b0);
        check("drain_div_op", div_op_o, ALU_DIV);
        @(negedge clk_i);
        check("drain_done_ready", req_ready_o, 1'b1);
        check("drain_done_div_op", div_op_o, ALU_NONE);
        issue("divu_9_2", 2'd1, 32'd9, 32'd2, 32'd4, 2);

        // Flush in DONE suppresses the pulse.
        act0        = div_active;
        req_valid_i = 1'b1; req_op_i = 2'd1; req_a_i = 32'd5; req_b_i = 32'd0;
        @(posedge clk_i); #1 req_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_done_busy", busy_o, 1'b1);
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_done_idle", req_ready_o, 1'b1);
        check("flush_done_no_div", div_active, act0);

        // Flush in IDLE drops the same-cycle request.
        req_valid_i = 1'b1; flush_i = 1'b1; req_op_i = 2'd0; req_a_i = 32'd100; req_b_i = 32'd7;
        @(posedge clk_i); #1 req_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle_busy", busy_o, 1'b0);
        check("flush_idle_div_op", div_op_o, ALU_NONE);

        // Watchdog: divider never finishes; err on the 40th RUN cycle, then idle.
        stall_len   = 1000;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_a_i = 32'd1000; req_b_i = 32'd3;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        acc       = cyc;
        err_cycle = acc + 39;
        err_pend  = 1'b1;
        wait_cyc(acc + 40);
        err_pend = 1'b0;
        check("timeout_ready", req_ready_o, 1'b1);
        check("timeout_div_op", div_op_o, ALU_NONE);

        // Reset mid-operation.
        stall_len   = 10;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_a_i = 32'd100; req_b_i = 32'd7;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        @(posedge clk_i); #1 reset_i = 1'b1;
        @(posedge clk_i); #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("midrst_ready", req_ready_o, 1'b1);
        check("midrst_div_op", div_op_o, ALU_NONE);
        check("midrst_div_a", div_a_o, 32'd0);
        check("midrst_div_neg", div_neg_o, 1'b0);
        check("midrst_data", rsp_data_o, 32'd0);
        issue("div_after_rst", 2'd0, 32'd100, 32'd7, 32'd14, 3);

        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
